instr_register_exec: RTL and testbench

Responder side of the lab instruction-register interface. It accepts instruction writes (opcode plus two operands at a write address), computes each instruction's result in a two-stage pipeline, and commits the instruction word with its result into a 32-entry register stack. A registered read port returns the stored word and result at a read address. It replaces the passive instruction register as the DUT driven by the lab test modules through `tb_ifc`.

---
 rtl/instr_register_exec_pkg.sv | 30 +++
 rtl/instr_register_exec_if.sv | 27 ++
 rtl/instr_register_exec_alu.sv | 55 +++++
 rtl/instr_register_exec.sv | 147 ++++++++++++++
 tb/tb_instr_register_exec.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_exec_pkg.sv
// Shared types for the instruction-register responder: opcode encoding,
// operand/result widths, stack address and the stored instruction word.
// Optional feature macro used by the top: INSTR_REG_BYPASS_EN.
package instr_register_pkg;

  localparam int unsigned NUM_ENTRIES = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic        [4:0]  address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;

endpackage

// File: rtl/instr_register_exec_if.sv
// Bus between the lab test driver (master) and the instruction-register
// responder (slave): write request, read address and read/status returns.
interface instr_register_exec_if;
  import instr_register_pkg::*;

  logic         load_en;
  address_t     write_pointer;
  opcode_t      opcode;
  operand_t     operand_a;
  operand_t     operand_b;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         rd_valid;
  logic         busy;
  logic         div_err;

  modport master (
    output load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
    input  instruction_word, rd_valid, busy, div_err
  );

  modport slave (
    input  load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
    output instruction_word, rd_valid, busy, div_err
  );

endinterface

// File: rtl/instr_register_exec_alu.sv
// instr_alu: purely combinational result computation for one instruction.
// All arithmetic is done on sign-extended 64-bit values so ADD/SUB/MULT
// never overflow. Division by zero yields 0 and raises div_zero.
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  result,
  output logic     div_zero
);

  result_t a_s;
  result_t b_s;

  // Decode the opcode into a 64-bit signed result and the divide-by-zero flag
  always_comb begin
    a_s      = result_t'(op_a);
    b_s      = result_t'(op_b);
    result   = 64'sd0;
    div_zero = 1'b0;
    case (opc)
      ZERO:  result = 64'sd0;
      PASSA: result = a_s;
      PASSB: result = b_s;
      ADD:   result = a_s + b_s;
      SUB:   result = a_s - b_s;
      MULT:  result = a_s * b_s;
      DIV: begin
        if (op_b == 32'sd0) begin
          result   = 64'sd0;
          div_zero = 1'b1;
        end else begin
          result   = a_s / b_s;
          div_zero = 1'b0;
        end
      end
      MOD: begin
        if (op_b == 32'sd0) begin
          result   = 64'sd0;
          div_zero = 1'b1;
        end else begin
          result   = a_s % b_s;
          div_zero = 1'b0;
        end
      end
      default: begin
        result   = 64'sd0;
        div_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_register_exec.sv
// instr_register_exec: responder side of the lab instruction register.
// Writes flow S1 (capture) -> S2 (result) -> commit into a 32-entry stack.
// The read port is registered; unwritten entries read back as all-zero.
// Optional feature: define INSTR_REG_BYPASS_EN to forward the word being
// committed to a read of the same address sampled on that edge.
// NUM_ENTRIES must equal 2**$bits(address_t).
module instr_register_exec
  import instr_register_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = instr_register_pkg::NUM_ENTRIES
)(
  input logic                  clk,
  input logic                  reset,
  instr_register_exec_if.slave bus
);

  // S1: captured request
  logic         s1_valid_d, s1_valid_q;
  instruction_t s1_word_d,  s1_word_q;
  address_t     s1_addr_d,  s1_addr_q;

  // S2: request with computed result
  logic         s2_valid_d,   s2_valid_q;
  instruction_t s2_word_d,    s2_word_q;
  address_t     s2_addr_d,    s2_addr_q;
  logic         s2_div_err_d, s2_div_err_q;

  // Committed state
  logic [NUM_ENTRIES-1:0] valid_d, valid_q;
  instruction_t           stack_q [NUM_ENTRIES];

  // Read port and status
  instruction_t rd_word_d,  rd_word_q;
  logic         rd_valid_d, rd_valid_q;
  logic         div_err_d,  div_err_q;

  result_t alu_result_s;
  logic    alu_div_zero_s;
  instruction_t rd_base_word_s;
  logic         rd_base_valid_s;

  instr_alu u_alu (
    .opc      (s1_word_q.opc),
    .op_a     (s1_word_q.op_a),
    .op_b     (s1_word_q.op_b),
    .result   (alu_result_s),
    .div_zero (alu_div_zero_s)
  );

  // S1 next state: take the request fields straight off the bus
  always_comb begin
    s1_valid_d     = bus.load_en;
    s1_word_d      = '0;
    s1_word_d.opc  = bus.opcode;
    s1_word_d.op_a = bus.operand_a;
    s1_word_d.op_b = bus.operand_b;
    s1_addr_d      = bus.write_pointer;
  end

  // S2 next state: S1 fields plus the ALU result and error flag
  always_comb begin
    s2_valid_d       = s1_valid_q;
    s2_word_d        = s1_word_q;
    s2_word_d.result = alu_result_s;
    s2_addr_d        = s1_addr_q;
    s2_div_err_d     = alu_div_zero_s;
  end

  // Commit bookkeeping and div_err pulse for the S2 word
  always_comb begin
    valid_d = valid_q;
    if (s2_valid_q) begin
      valid_d[s2_addr_q] = 1'b1;
      div_err_d          = s2_div_err_q;
    end else begin
      div_err_d          = 1'b0;
    end
  end

  // Read mux: committed content, zero when not valid
  always_comb begin
    rd_base_valid_s = valid_q[bus.read_pointer];
    if (rd_base_valid_s) begin
      rd_base_word_s = stack_q[bus.read_pointer];
    end else begin
      rd_base_word_s = '0;
    end
  end

  // Read next state, optionally forwarding the word committing this edge
  always_comb begin
`ifdef INSTR_REG_BYPASS_EN
    if (s2_valid_q && (s2_addr_q == bus.read_pointer)) begin
      rd_word_d  = s2_word_q;
      rd_valid_d = 1'b1;
    end else begin
      rd_word_d  = rd_base_word_s;
      rd_valid_d = rd_base_valid_s;
    end
`else
    rd_word_d  = rd_base_word_s;
    rd_valid_d = rd_base_valid_s;
`endif
  end

  // Pipeline, valid bits and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_word_q    <= '0;
      s1_addr_q    <= 5'd0;
      s2_valid_q   <= 1'b0;
      s2_word_q    <= '0;
      s2_addr_q    <= 5'd0;
      s2_div_err_q <= 1'b0;
      valid_q      <= '0;
      rd_word_q    <= '0;
      rd_valid_q   <= 1'b0;
      div_err_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_word_q    <= s1_word_d;
      s1_addr_q    <= s1_addr_d;
      s2_valid_q   <= s2_valid_d;
      s2_word_q    <= s2_word_d;
      s2_addr_q    <= s2_addr_d;
      s2_div_err_q <= s2_div_err_d;
      valid_q      <= valid_d;
      rd_word_q    <= rd_word_d;
      rd_valid_q   <= rd_valid_d;
      div_err_q    <= div_err_d;
    end
  end

  // Stack data array; not cleared by reset since valid bits gate reads
  always_ff @(posedge clk) begin
    if (s2_valid_q && !reset) begin
      stack_q[s2_addr_q] <= s2_word_q;
    end
  end

  assign bus.instruction_word = rd_word_q;
  assign bus.rd_valid         = rd_valid_q;
  assign bus.div_err          = div_err_q;
  assign bus.busy             = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_instr_register_exec.sv
// Directed self-checking bench for instr_register_exec. Inputs change 1 time
// unit after a rising edge; outputs are checked at that same point, so a
// check after "edge K" sees the state registered at edge K.
module tb_instr_register_exec;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  instr_register_exec_if bus ();

  instr_register_exec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input address_t addr, input opcode_t opc,
                          input operand_t a, input operand_t b);
    bus.load_en       = 1'b1;
    bus.write_pointer = addr;
    bus.opcode        = opc;
    bus.operand_a     = a;
    bus.operand_b     = b;
    tick();
    bus.load_en       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL reset_div_err: got %0b expected 0", bus.div_err); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b expected 0", bus.rd_valid); end
    checks++; if (bus.instruction_word !== '0) begin errors++; $display("FAIL reset_word: got %h expected 0", bus.instruction_word); end
    for (int i = 0; i < 32; i++) begin
      bus.read_pointer = address_t'(i);
      tick();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_read_valid[%0d]: got %0b expected 0", i, bus.rd_valid); end
      checks++; if (bus.instruction_word !== '0) begin errors++; $display("FAIL reset_read_word[%0d]: got %h expected 0", i, bus.instruction_word); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %0b expected 0", bus.busy); end
  endtask

  task automatic test_add();
    bus.read_pointer = 5'd3;
    do_write(5'd3, ADD, -32'sd15, 32'sd15);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL add_busy_n1: got %0b expected 1", bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL add_busy_n2: got %0b expected 1", bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL add_busy_n3: got %0b expected 0", bus.busy); end
    tick();
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL add_rd_valid: got %0b expected 1", bus.rd_valid); end
    checks++; if (bus.instruction_word.result !== 64'sd0) begin errors++; $display("FAIL add_result: got %0d expected 0", bus.instruction_word.result); end
    checks++; if (bus.instruction_word.opc !== ADD) begin errors++; $display("FAIL add_opc: got %0d expected %0d", bus.instruction_word.opc, ADD); end
    checks++; if (bus.instruction_word.op_a !== -32'sd15) begin errors++; $display("FAIL add_op_a: got %0d expected -15", bus.instruction_word.op_a); end
    checks++; if (bus.instruction_word.op_b !== 32'sd15) begin errors++; $display("FAIL add_op_b: got %0d expected 15", bus.instruction_word.op_b); end
  endtask

  task automatic test_arith();
    address_t addrs [4];
    result_t  exp   [4];
    addrs = '{5'd5, 5'd6, 5'd7, 5'd12};
    exp   = '{64'sh00000000FFFFFFFE, -64'sd3, -64'sd1, 64'sd0};
    do_write(5'd5, MULT, 32'sh7FFFFFFF, 32'sd2);
    do_write(5'd6, DIV, -32'sd7, 32'sd2);
    do_write(5'd7, MOD, -32'sd7, 32'sd2);
    do_write(5'd12, opcode_t'(4'd9), 32'sd5, 32'sd0);
    tick();
    tick();
    checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL arith_illegal_no_err: got %0b expected 0", bus.div_err); end
    for (int i = 0; i < 4; i++) begin
      bus.read_pointer = addrs[i];
      tick();
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL arith_valid[%0d]: got %0b expected 1", addrs[i], bus.rd_valid); end
      checks++; if (bus.instruction_word.result !== exp[i]) begin errors++; $display("FAIL arith_result[%0d]: got %h expected %h", addrs[i], bus.instruction_word.result, exp[i]); end
    end
  endtask

  task automatic test_div_zero();
    do_write(5'd8, DIV, 32'sd9, 32'sd0);
    checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL dz_n1: got %0b expected 0", bus.div_err); end
    tick();
    checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL dz_n2: got %0b expected 0", bus.div_err); end
    tick();
    checks++; if (bus.div_err !== 1'b1) begin errors++; $display("FAIL dz_n3: got %0b expected 1", bus.div_err); end
    tick();
    checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL dz_n4: got %0b expected 0", bus.div_err); end
    bus.read_pointer = 5'd8;
    tick();
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL dz_valid: got %0b expected 1", bus.rd_valid); end
    checks++; if (bus.instruction_word.result !== 64'sd0) begin errors++; $display("FAIL dz_result: got %0d expected 0", bus.instruction_word.result); end
    do_write(5'd20, MOD, 32'sd1, 32'sd0);
    do_write(5'd21, DIV, 32'sd2, 32'sd0);
    tick();
    checks++; if (bus.div_err !== 1'b1) begin errors++; $display("FAIL dz_b2b_first: got %0b expected 1", bus.div_err); end
    tick();
    checks++; if (bus.div_err !== 1'b1) begin errors++; $display("FAIL dz_b2b_second: got %0b expected 1", bus.div_err); end
    tick();
    checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL dz_b2b_end: got %0b expected 0", bus.div_err); end
  endtask

  task automatic test_back_to_back();
    address_t rd_list [8];
    result_t  exp_res;
    opcode_t  exp_opc;
    rd_list = '{5'd7, 5'd4, 5'd0, 5'd9, 5'd2, 5'd4, 5'd5, 5'd1};
    for (int i = 0; i < 10; i++) begin
      do_write(address_t'(i), ADD, operand_t'(i * 100), operand_t'(i));
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d]: got %0b expected 1", i, bus.busy); end
    end
    do_write(5'd4, PASSB, 32'sd77, 32'sd11);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.read_pointer = rd_list[i];
      if (rd_list[i] == 5'd4) begin
        exp_res = 64'sd11;
        exp_opc = PASSB;
      end else begin
        exp_res = result_t'(rd_list[i]) * 64'sd101;
        exp_opc = ADD;
      end
      tick();
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", rd_list[i], bus.rd_valid); end
      checks++; if (bus.instruction_word.result !== exp_res) begin errors++; $display("FAIL b2b_result[%0d]: got %0d expected %0d", rd_list[i], bus.instruction_word.result, exp_res); end
      checks++; if (bus.instruction_word.opc !== exp_opc) begin errors++; $display("FAIL b2b_opc[%0d]: got %0d expected %0d", rd_list[i], bus.instruction_word.opc, exp_opc); end
    end
  endtask

  task automatic test_reset_mid();
    do_write(5'd2, PASSA, 32'sd99, 32'sd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b expected 0", bus.busy); end
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_late: got %0b expected 0", bus.busy); end
    bus.read_pointer = 5'd2;
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b expected 0", bus.rd_valid); end
    checks++; if (bus.instruction_word !== '0) begin errors++; $display("FAIL rmid_word: got %h expected 0", bus.instruction_word); end
    reset             = 1'b1;
    bus.load_en       = 1'b1;
    bus.write_pointer = 5'd10;
    bus.opcode        = PASSA;
    bus.operand_a     = 32'sd5;
    bus.operand_b     = 32'sd0;
    tick();
    reset       = 1'b0;
    bus.load_en = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rwr_busy: got %0b expected 0", bus.busy); end
    tick();
    tick();
    bus.read_pointer = 5'd10;
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rwr_valid: got %0b expected 0", bus.rd_valid); end
  endtask

  task automatic test_bypass();
    result_t exp_commit;
`ifdef INSTR_REG_BYPASS_EN
    exp_commit = 64'sd123;
`else
    exp_commit = 64'sd50;
`endif
    do_write(5'd6, PASSA, 32'sd50, 32'sd0);
    tick();
    tick();
    bus.read_pointer = 5'd6;
    do_write(5'd6, PASSA, 32'sd123, 32'sd0);
    tick();
    checks++; if (bus.instruction_word.result !== 64'sd50) begin errors++; $display("FAIL byp_before: got %0d expected 50", bus.instruction_word.result); end
    tick();
    checks++; if (bus.instruction_word.result !== exp_commit) begin errors++; $display("FAIL byp_commit_edge: got %0d expected %0d", bus.instruction_word.result, exp_commit); end
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL byp_commit_valid: got %0b expected 1", bus.rd_valid); end
    tick();
    checks++; if (bus.instruction_word.result !== 64'sd123) begin errors++; $display("FAIL byp_after: got %0d expected 123", bus.instruction_word.result); end
    checks++; if (bus.instruction_word.op_a !== 32'sd123) begin errors++; $display("FAIL byp_after_op_a: got %0d expected 123", bus.instruction_word.op_a); end
  endtask

  initial begin
    reset             = 1'b1;
    bus.load_en       = 1'b0;
    bus.write_pointer = 5'd0;
    bus.opcode        = ZERO;
    bus.operand_a     = 32'sd0;
    bus.operand_b     = 32'sd0;
    bus.read_pointer  = 5'd0;
    test_reset();
    test_add();
    test_arith();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
